// File: rtl/timing_multi.sv
// Bank of NUM_CH independent up-counting timers sharing one free-running prescaler,
// each with one-shot/periodic mode, sticky pending/overrun flags and an interrupt enable.
module timing_multi #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ro_trig_start,
  input  logic [NUM_CH-1:0]       ro_trig_halt,
  input  logic [NUM_CH-1:0]       ro_mode,
  input  logic [NUM_CH*WIDTH-1:0] ro_termcount,
  input  logic [PRESCALE_W-1:0]   ro_prescale,
  input  logic [NUM_CH-1:0]       ro_int_en,
  input  logic [NUM_CH-1:0]       ro_int_clr,
  output logic [NUM_CH-1:0]       rf_status,
  output logic [NUM_CH*WIDTH-1:0] rf_currcount,
  output logic [NUM_CH-1:0]       rf_int_pend,
  output logic [NUM_CH-1:0]       rf_overrun,
  output logic                    rf_int
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [PRESCALE_W-1:0] pre_cnt_r;
  logic                  tick_s;

  // A >= compare lets a lowered reload fire on the next clock instead of locking up.
  assign tick_s = (pre_cnt_r >= ro_prescale);

  // Shared prescaler counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_r <= '0;
    end else if (tick_s) begin
      pre_cnt_r <= '0;
    end else begin
      pre_cnt_r <= pre_cnt_r + PRESCALE_W'(1);
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    state_t           state_r;
    logic             run_r;
    logic [WIDTH-1:0] count_r;
    logic             pend_r;
    logic             ovr_r;
    logic [WIDTH-1:0] term_s;
    logic             event_s;

    assign term_s  = ro_termcount[ch*WIDTH +: WIDTH];
    // Halt and start both pre-empt the tick, so neither can coincide with a terminal event.
    assign event_s = (state_r == ST_RUN) && tick_s && !ro_trig_halt[ch] &&
                     !ro_trig_start[ch] && (count_r == term_s);

    // Channel FSM, counter and sticky interrupt flags
    always_ff @(posedge clk) begin
      if (reset) begin
        state_r <= ST_IDLE;
        run_r   <= 1'b0;
        count_r <= '0;
        pend_r  <= 1'b0;
        ovr_r   <= 1'b0;
      end else begin
        if (ro_trig_halt[ch]) begin
          state_r <= ST_IDLE;
          run_r   <= 1'b0;
        end else if (ro_trig_start[ch]) begin
          state_r <= ST_RUN;
          run_r   <= 1'b1;
          count_r <= '0;
        end else begin
          case (state_r)
            ST_RUN: begin
              if (tick_s) begin
                if (count_r != term_s) begin
                  count_r <= count_r + WIDTH'(1);
                end else if (ro_mode[ch]) begin
                  count_r <= '0;
                end else begin
                  state_r <= ST_DONE;
                  run_r   <= 1'b0;
                end
              end
            end
            ST_IDLE, ST_DONE: begin
              run_r <= 1'b0;
            end
            default: begin
              state_r <= ST_IDLE;
              run_r   <= 1'b0;
            end
          endcase
        end

        // A new event outranks a same-cycle clear.
        if (event_s) begin
          pend_r <= 1'b1;
          if (pend_r) begin
            ovr_r <= 1'b1;
          end
        end else if (ro_int_clr[ch]) begin
          pend_r <= 1'b0;
          ovr_r  <= 1'b0;
        end
      end
    end

    assign rf_status[ch]                    = run_r;
    assign rf_currcount[ch*WIDTH +: WIDTH]  = count_r;
    assign rf_int_pend[ch]                  = pend_r;
    assign rf_overrun[ch]                   = ovr_r;
  end

  assign rf_int = |(rf_int_pend & ro_int_en);

endmodule

// File: tb/tb_timing_multi.sv
// Directed bench for timing_multi, built with 8-bit counters so the
// counter wrap-around can be reached in a short run.
module tb_timing_multi;
  localparam int NUM_CH     = 4;
  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       ro_trig_start;
  logic [NUM_CH-1:0]       ro_trig_halt;
  logic [NUM_CH-1:0]       ro_mode;
  logic [NUM_CH*WIDTH-1:0] ro_termcount;
  logic [PRESCALE_W-1:0]   ro_prescale;
  logic [NUM_CH-1:0]       ro_int_en;
  logic [NUM_CH-1:0]       ro_int_clr;
  logic [NUM_CH-1:0]       rf_status;
  logic [NUM_CH*WIDTH-1:0] rf_currcount;
  logic [NUM_CH-1:0]       rf_int_pend;
  logic [NUM_CH-1:0]       rf_overrun;
  logic                    rf_int;

  int tests = 0;
  int fails = 0;

  timing_multi #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .ro_trig_start (ro_trig_start),
    .ro_trig_halt  (ro_trig_halt),
    .ro_mode       (ro_mode),
    .ro_termcount  (ro_termcount),
    .ro_prescale   (ro_prescale),
    .ro_int_en     (ro_int_en),
    .ro_int_clr    (ro_int_clr),
    .rf_status     (rf_status),
    .rf_currcount  (rf_currcount),
    .rf_int_pend   (rf_int_pend),
    .rf_overrun    (rf_overrun),
    .rf_int        (rf_int)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] cnt(input int i);
    return rf_currcount[i*WIDTH +: WIDTH];
  endfunction

  initial begin
    reset         = 1'b1;
    ro_trig_start = 4'h0;
    ro_trig_halt  = 4'h0;
    ro_mode       = 4'h0;
    ro_termcount  = 32'h0;
    ro_prescale   = 8'd0;
    ro_int_en     = 4'h0;
    ro_int_clr    = 4'h0;

    // Reset, then idle without any start
    cyc(3);
    reset = 1'b0;
    check("rst_status", rf_status, 4'h0);
    check("rst_count", rf_currcount, 32'h0);
    check("rst_pend", rf_int_pend, 4'h0);
    check("rst_ovr", rf_overrun, 4'h0);
    check("rst_int", rf_int, 1'b0);
    cyc(20);
    check("idle_count", rf_currcount, 32'h0);
    check("idle_status", rf_status, 4'h0);

    // One-shot ch0, termcount 5, prescale 0
    ro_termcount[0*WIDTH +: WIDTH] = 8'd5;
    ro_int_en = 4'h1;
    ro_trig_start = 4'h1;
    cyc(1);
    ro_trig_start = 4'h0;
    check("os_status0", rf_status[0], 1'b1);
    check("os_count0", cnt(0), 8'd0);
    for (int n = 1; n <= 5; n++) begin
      cyc(1);
      check("os_count_n", cnt(0), n[7:0]);
    end
    check("os_pend_early", rf_int_pend[0], 1'b0);
    cyc(1);
    check("os_done_status", rf_status[0], 1'b0);
    check("os_done_count", cnt(0), 8'd5);
    check("os_done_pend", rf_int_pend[0], 1'b1);
    check("os_done_int", rf_int, 1'b1);
    cyc(2);
    check("os_hold_count", cnt(0), 8'd5);
    ro_int_clr = 4'h1;
    cyc(1);
    ro_int_clr = 4'h0;
    check("os_clr_pend", rf_int_pend[0], 1'b0);
    check("os_clr_int", rf_int, 1'b0);

    // Periodic ch1, termcount 2, prescale 3; ticks land 3,7,11,... edges after start
    ro_termcount[1*WIDTH +: WIDTH] = 8'd2;
    ro_mode = 4'h2;
    ro_prescale = 8'd3;
    ro_trig_start = 4'h2;
    cyc(1);
    ro_trig_start = 4'h0;
    check("per_c0", cnt(1), 8'd0);
    cyc(2);
    check("per_c0_hold", cnt(1), 8'd0);
    cyc(1);
    check("per_c1", cnt(1), 8'd1);
    cyc(3);
    check("per_c1_hold", cnt(1), 8'd1);
    cyc(1);
    check("per_c2", cnt(1), 8'd2);
    cyc(3);
    check("per_pend_before", rf_int_pend[1], 1'b0);
    cyc(1);
    check("per_wrap0", cnt(1), 8'd0);
    check("per_pend1", rf_int_pend[1], 1'b1);
    check("per_ovr0", rf_overrun[1], 1'b0);
    check("per_int_masked", rf_int, 1'b0);
    cyc(12);
    check("per_pend2", rf_int_pend[1], 1'b1);
    check("per_ovr1", rf_overrun[1], 1'b1);
    cyc(11);
    ro_int_clr = 4'h2;
    cyc(1);
    ro_int_clr = 4'h0;
    check("per_setwins_pend", rf_int_pend[1], 1'b1);
    check("per_setwins_ovr", rf_overrun[1], 1'b1);
    ro_int_clr = 4'h2;
    cyc(1);
    ro_int_clr = 4'h0;
    check("per_clr_pend", rf_int_pend[1], 1'b0);
    check("per_clr_ovr", rf_overrun[1], 1'b0);
    ro_trig_halt = 4'h2;
    ro_prescale = 8'd0;
    cyc(1);
    ro_trig_halt = 4'h0;
    check("per_halted", rf_status[1], 1'b0);

    // Halt / restart on ch2, termcount 100
    ro_termcount[2*WIDTH +: WIDTH] = 8'd100;
    ro_trig_start = 4'h4;
    cyc(1);
    ro_trig_start = 4'h0;
    cyc(37);
    check("hr_c37", cnt(2), 8'd37);
    ro_trig_halt = 4'h4;
    cyc(1);
    ro_trig_halt = 4'h0;
    check("hr_halt_status", rf_status[2], 1'b0);
    check("hr_halt_count", cnt(2), 8'd37);
    cyc(5);
    check("hr_frozen", cnt(2), 8'd37);
    ro_trig_start = 4'h4;
    cyc(1);
    ro_trig_start = 4'h0;
    check("hr_restart_count", cnt(2), 8'd0);
    check("hr_restart_status", rf_status[2], 1'b1);
    cyc(3);
    check("hr_c3", cnt(2), 8'd3);
    ro_trig_start = 4'h4;
    ro_trig_halt = 4'h4;
    cyc(1);
    ro_trig_start = 4'h0;
    ro_trig_halt = 4'h0;
    check("hr_both_status", rf_status[2], 1'b0);
    check("hr_both_count", cnt(2), 8'd3);

    // Live termcount lowering on ch3 (periodic)
    ro_termcount[3*WIDTH +: WIDTH] = 8'd100;
    ro_mode = 4'h8;
    ro_trig_start = 4'h8;
    cyc(1);
    ro_trig_start = 4'h0;
    cyc(50);
    check("lt_c50", cnt(3), 8'd50);
    ro_termcount[3*WIDTH +: WIDTH] = 8'd10;
    cyc(205);
    check("lt_c255", cnt(3), 8'd255);
    cyc(1);
    check("lt_wrap_count", cnt(3), 8'd0);
    check("lt_wrap_nopend", rf_int_pend[3], 1'b0);
    cyc(10);
    check("lt_c10", cnt(3), 8'd10);
    check("lt_c10_nopend", rf_int_pend[3], 1'b0);
    cyc(1);
    check("lt_event_count", cnt(3), 8'd0);
    check("lt_event_pend", rf_int_pend[3], 1'b1);

    // All channels periodic, termcount 0, then reset mid-run
    ro_termcount = 32'h0;
    ro_mode = 4'hf;
    ro_int_clr = 4'hf;
    ro_trig_start = 4'hf;
    cyc(1);
    ro_trig_start = 4'h0;
    ro_int_clr = 4'h0;
    check("all_start_status", rf_status, 4'hf);
    check("all_start_pend", rf_int_pend, 4'h0);
    cyc(1);
    check("all_ev1_pend", rf_int_pend, 4'hf);
    check("all_ev1_ovr", rf_overrun, 4'h0);
    check("all_ev1_count", rf_currcount, 32'h0);
    ro_int_en = 4'hf;
    cyc(1);
    check("all_ev2_pend", rf_int_pend, 4'hf);
    check("all_ev2_ovr", rf_overrun, 4'hf);
    check("all_int", rf_int, 1'b1);
    reset = 1'b1;
    cyc(1);
    check("mid_rst_status", rf_status, 4'h0);
    check("mid_rst_count", rf_currcount, 32'h0);
    check("mid_rst_pend", rf_int_pend, 4'h0);
    check("mid_rst_ovr", rf_overrun, 4'h0);
    check("mid_rst_int", rf_int, 1'b0);
    reset = 1'b0;
    cyc(3);
    check("post_rst_status", rf_status, 4'h0);
    check("post_rst_pend", rf_int_pend, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
